// File: rtl/adc_pkg.sv
// adc_pkg: framing constants and FSM states for the ADC128S022 emulator.
package adc_pkg;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_ADDR_FIRST = 2;
  localparam int ADC_ADDR_LAST  = 4;
  localparam int ADC_DATA_W     = 12;
  localparam int ADC_NCH        = 8;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} adc_state_e;
endpackage

// File: rtl/adc128s022_emulator_sync_edge.sv
// sync_edge: multi-flop synchronizer with rise/fall pulses on the synchronized level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/adc128s022_emulator.sv
// adc128s022_emulator: converter side of the ADC128S022 serial link, serving an 8 x 12-bit channel bank.
module adc128s022_emulator
  import adc_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic                  adc_sck,
  input  logic                  adc_cs_n,
  input  logic                  din,
  output logic                  dout,
  input  logic                  ch_wr_en,
  input  logic [2:0]            ch_wr_addr,
  input  logic [ADC_DATA_W-1:0] ch_wr_data,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [2:0]            last_addr
);
  logic                      w_sck_rise, w_sck_fall, w_sck_lvl;
  logic                      w_cs_rise, w_cs_fall, w_cs_lvl;
  logic                      w_din;
  logic [ADC_FRAME_BITS-1:0] w_fw;
  adc_state_e                r_state;
  logic [ADC_DATA_W-1:0]     r_bank [ADC_NCH];
  logic [2:0]                r_next_addr, r_addr_sr;
  logic [ADC_FRAME_BITS-1:0] r_sr;
  logic [4:0]                r_bit_cnt;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (.clk(clk_50M), .rst_n(rst_n), .i_d(adc_sck),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk_50M), .rst_n(rst_n), .i_d(adc_cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_din (.clk(clk_50M), .rst_n(rst_n), .i_d(din),
    .o_level(w_din), .o_rise(), .o_fall());

  // Bank read sees the pre-write value, so a write in the load cycle lands in the next frame.
  assign w_fw = {{ADC_LEAD_ZEROS{1'b0}}, r_bank[r_next_addr]};

  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      r_state     <= WAIT_IDLE;
      r_bank      <= '{default: '0};
      r_next_addr <= 3'(RESET_ADDR);
      last_addr   <= 3'(RESET_ADDR);
      r_addr_sr   <= '0;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      dout        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (ch_wr_en) r_bank[ch_wr_addr] <= ch_wr_data;
      case (r_state)
        WAIT_IDLE: begin
          dout <= 1'b0;
          if (w_cs_lvl) r_state <= IDLE;
        end
        IDLE:
          if (w_cs_fall) begin
            r_sr      <= w_fw;
            dout      <= w_fw[ADC_FRAME_BITS-1];
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end else dout <= 1'b0;
        SHIFT:
          if (w_cs_rise) begin
            frame_err <= 1'b1;
            dout      <= 1'b0;
            r_state   <= IDLE;
          end else if (w_sck_rise) begin
            if (r_bit_cnt >= 5'(ADC_ADDR_FIRST) && r_bit_cnt <= 5'(ADC_ADDR_LAST))
              r_addr_sr <= {r_addr_sr[1:0], w_din};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'(ADC_FRAME_BITS - 1)) begin
              r_next_addr <= r_addr_sr;
              last_addr   <= r_addr_sr;
              frame_done  <= 1'b1;
              dout        <= 1'b0;
              r_state     <= DONE;
            end
          end else if (w_sck_fall) begin
            r_sr <= {r_sr[ADC_FRAME_BITS-2:0], 1'b0};
            dout <= r_sr[ADC_FRAME_BITS-2];
          end
        DONE: begin
          dout <= 1'b0;
          if (w_cs_rise) r_state <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
endmodule
